// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice with fully registered ready and data; 1-cycle latency, 1 word/cycle.
// Stalls absorb one word in the skid register; define SKID_BUFFER_FLUSH_EN to add the Flush input.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
`ifdef SKID_BUFFER_FLUSH_EN
    input  logic             Flush,
`endif
    output logic [1:0]       Occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             flush_w;
    logic             in_xfer;
    logic             out_xfer;

`ifdef SKID_BUFFER_FLUSH_EN
    assign flush_w = Flush;
`else
    assign flush_w = 1'b0;
`endif

    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    out_d   = InData;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    out_d   = InData;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = InData;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = BUSY;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only needs to kill the state; stale data words are harmless once invalid.
        if (flush_w) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        InReady   = (state_q != FULL) & ~reset;
        OutValid  = (state_q != EMPTY);
        OutData   = out_q;
        case (state_q)
            EMPTY:   Occupancy = 2'd0;
            BUSY:    Occupancy = 2'd1;
            FULL:    Occupancy = 2'd2;
            default: Occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and scoreboard checks for skid_buffer at WIDTH=8.
module tb_skid_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       InValid;
    logic       InReady;
    logic [7:0] InData;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutData;
    logic [1:0] Occupancy;
`ifdef SKID_BUFFER_FLUSH_EN
    logic       Flush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skid_buffer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
`ifdef SKID_BUFFER_FLUSH_EN
        .Flush     (Flush),
`endif
        .Occupancy (Occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] nxt;
    logic       in_x, out_x;

    initial begin
        reset    = 1'b1;
        InValid  = 1'b1;
        InData   = 8'h5A;
        OutReady = 1'b0;
`ifdef SKID_BUFFER_FLUSH_EN
        Flush    = 1'b0;
`endif
        // Reset held two cycles with a word offered
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_vld", OutValid, 0);
            check("rst_rdy", InReady, 0);
            check("rst_occ", Occupancy, 0);
            check("rst_dat", OutData, 0);
        end
        reset   = 1'b0;
        InValid = 1'b0;
        #1;
        check("rst_rel_rdy", InReady, 1);
        step();
        check("rst_rel_vld", OutValid, 0);
        check("rst_rel_rdy2", InReady, 1);

        // Streaming 0x01..0x10
        OutReady = 1'b1;
        InValid  = 1'b1;
        InData   = 8'h01;
        step();
        for (int k = 1; k <= 16; k++) begin
            check("strm_vld", OutValid, 1);
            check("strm_dat", OutData, k);
            check("strm_occ", Occupancy, 1);
            check("strm_rdy", InReady, 1);
            if (k < 16) InData = 8'(k + 1);
            else        InValid = 1'b0;
            step();
        end
        check("strm_end_occ", Occupancy, 0);
        check("strm_end_vld", OutValid, 0);

        // Stall: fill to FULL then drain
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'hA1;
        step();
        InData   = 8'hA2;
        step();
        InValid  = 1'b0;
        check("stall_occ", Occupancy, 2);
        check("stall_rdy", InReady, 0);
        check("stall_dat", OutData, 8'hA1);
        step();
        check("stall_hold_dat", OutData, 8'hA1);
        check("stall_hold_vld", OutValid, 1);
        OutReady = 1'b1;
        step();
        check("stall_pop1_dat", OutData, 8'hA2);
        check("stall_pop1_rdy", InReady, 1);
        check("stall_pop1_occ", Occupancy, 1);
        step();
        check("stall_pop2_vld", OutValid, 0);

        // Offer while FULL and popping, then in+out in BUSY
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'hB1;
        step();
        InData   = 8'hB2;
        step();
        InData   = 8'hB3;
        OutReady = 1'b1;
        step();
        check("full_io_dat", OutData, 8'hB2);
        check("full_io_occ", Occupancy, 1);
        check("full_io_rdy", InReady, 1);
        step();
        check("busy_io_dat", OutData, 8'hB3);
        check("busy_io_occ", Occupancy, 1);
        InValid = 1'b0;
        step();
        check("busy_io_end", Occupancy, 0);

        // Random traffic against a queue model
        nxt      = 8'h00;
        InData   = nxt;
        InValid  = 1'b0;
        OutReady = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check("rnd_occ", Occupancy, q.size());
            check("rnd_vld", OutValid, q.size() != 0);
            if (OutValid && q.size() != 0) check("rnd_dat", OutData, q[0]);
            in_x  = InValid & InReady;
            out_x = OutValid & OutReady;
            @(posedge clk);
            if (out_x && q.size() != 0) void'(q.pop_front());
            if (in_x) q.push_back(InData);
            #1;
            if (in_x) nxt = nxt + 8'd1;
            if (!InValid || in_x) begin
                InValid = 1'($urandom_range(0, 1));
                InData  = nxt;
            end
            OutReady = 1'($urandom_range(0, 1));
        end

        // Reset while FULL with 0x55,0x66
        InValid  = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) step();
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h55;
        step();
        InData   = 8'h66;
        step();
        check("mid_pre_occ", Occupancy, 2);
        reset   = 1'b1;
        InData  = 8'h99;
        step();
        check("mid_rst_vld", OutValid, 0);
        check("mid_rst_occ", Occupancy, 0);
        reset    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_after_vld", OutValid, 0);
        end

`ifdef SKID_BUFFER_FLUSH_EN
        // Flush in FULL with a word offered
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h11;
        step();
        InData   = 8'h22;
        step();
        InData   = 8'h77;
        Flush    = 1'b1;
        step();
        Flush    = 1'b0;
        InValid  = 1'b0;
        check("fl_occ", Occupancy, 0);
        check("fl_vld", OutValid, 0);
        check("fl_rdy", InReady, 1);
        OutReady = 1'b1;
        InValid  = 1'b1;
        InData   = 8'h88;
        step();
        InValid  = 1'b0;
        check("fl_next_dat", OutData, 8'h88);
        check("fl_next_vld", OutValid, 1);
        step();
        // Flush in BUSY drops the coincident accepted word
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h33;
        step();
        InData   = 8'h44;
        Flush    = 1'b1;
        step();
        Flush    = 1'b0;
        InValid  = 1'b0;
        check("flb_occ", Occupancy, 0);
        check("flb_vld", OutValid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
